alu_accum_fsm: RTL and testbench

- Parametrised accumulator ALU with a small control FSM.
- Generalises the existing 8-bit persist/load/reset datapath to WIDTH bits.
- Adds a start/busy/done handshake, a multi-cycle multiply, and carry/zero/overflow status flags.
- Sits between operand sources (num1, num2) and the result bus. Exposes curr_state and next_state for debug and bench display.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_shift_add_mul.sv | 59 +++++
 rtl/alu_accum_fsm.sv | 158 +++++++++++++++
 tb/tb_alu_accum_fsm.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the accumulator ALU: FSM states, opcodes, mode-select bits.
package alu_pkg;

  typedef enum logic [1:0] {
    S_CLR  = 2'b00,
    S_LOAD = 2'b01,
    S_HOLD = 2'b10,
    S_MUL  = 2'b11
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  localparam int unsigned IS_RESET   = 0;
  localparam int unsigned IS_LOAD    = 1;
  localparam int unsigned IS_PERSIST = 2;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles, abortable.
module alu_shift_add_mul #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done_c,
  output logic [CNT_W-1:0]   cnt,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    step_c;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Partial product after the current step; on the last step this is the full product.
  assign step_c    = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign product_c = step_c;
  assign done_c    = busy_q && (cnt_q == CNT_W'(1));
  assign busy      = busy_q;
  assign cnt       = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      prod_q   <= step_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (done_c) busy_q <= 1'b0;
    end else if (start) begin
      mcand_q  <= PW'(a);
      prod_q   <= '0;
      mplier_q <= b;
      cnt_q    <= CNT_W'(WIDTH);
      busy_q   <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_accum_fsm.sv
// Accumulator ALU with persist/load/clear modes, start/busy/done handshake and status flags.
module alu_accum_fsm
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       in_sel,
  input  logic [3:0]       out_sel,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [1:0]       curr_state,
  output logic [1:0]       next_state
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state_q, state_d, sel_state;
  logic [WIDTH-1:0] acc_q, op_a, alu_res;
  logic [WIDTH:0]   sum;
  logic             carry_q, ovf_q, done_q;
  logic             alu_c, alu_v, op_valid;
  logic             sel_reset, sel_load, is_mul;
  logic             mul_start, mul_busy, mul_done;
  logic [CNT_W-1:0] mul_cnt;
  logic [PW-1:0]    mul_prod;

  // Mode decode with priority reset > load > persist; 000 falls into persist.
  always_comb begin
    sel_reset = 1'b0;
    sel_load  = 1'b0;
    casez (in_sel)
      3'b??1:  sel_reset = 1'b1;
      3'b?10:  sel_load  = 1'b1;
      default: ;
    endcase
  end

  assign sel_state = sel_load ? S_LOAD : S_HOLD;
  assign op_a      = sel_load ? num1 : acc_q;
  assign is_mul    = (out_sel == OP_MUL);
  assign mul_start = start && is_mul && !sel_reset && (state_q != S_MUL);

  always_comb begin
    alu_res  = acc_q;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    op_valid = 1'b1;
    sum      = '0;
    case (out_sel)
      OP_ADD: begin
        sum     = {1'b0, op_a} + {1'b0, num2};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == num2[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, op_a} - {1'b0, num2};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] != num2[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & num2;
      OP_OR:   alu_res = op_a | num2;
      OP_XOR:  alu_res = op_a ^ num2;
      OP_NOT:  alu_res = ~op_a;
      OP_SHL: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      OP_PASS: alu_res = num2;
      default: op_valid = 1'b0;
    endcase
  end

  // Next state: clear wins, MUL holds until its last step, otherwise follow the mode.
  always_comb begin
    state_d = sel_state;
    if (sel_reset) begin
      state_d = S_CLR;
    end else if (state_q == S_MUL) begin
      state_d = (mul_cnt == CNT_W'(1)) ? sel_state : S_MUL;
    end else if (start && is_mul) begin
      state_d = S_MUL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLR;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (sel_reset) begin
        acc_q   <= '0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (state_q == S_MUL) begin
        if (mul_done) begin
          acc_q   <= mul_prod[WIDTH-1:0];
          carry_q <= 1'b0;
          ovf_q   <= |mul_prod[PW-1:WIDTH];
          done_q  <= 1'b1;
        end
      end else if (start && !is_mul) begin
        done_q <= 1'b1;
        if (op_valid) begin
          acc_q   <= alu_res;
          carry_q <= alu_c;
          ovf_q   <= alu_v;
        end
      end
    end
  end

  alu_shift_add_mul #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mul_start),
    .abort    (sel_reset),
    .a        (op_a),
    .b        (num2),
    .busy     (mul_busy),
    .done_c   (mul_done),
    .cnt      (mul_cnt),
    .product_c(mul_prod)
  );

  assign out        = acc_q;
  assign carry      = carry_q;
  assign overflow   = ovf_q;
  assign done       = done_q;
  assign busy       = mul_busy;
  assign zero       = (acc_q == '0);
  assign curr_state = state_q;
  assign next_state = state_d;

endmodule

// File: tb/tb_alu_accum_fsm.sv
// Directed bench for alu_accum_fsm: vector table for single-cycle ops plus MUL/abort/async-reset sequences.
module tb_alu_accum_fsm;

  logic       clk, rst_n, start;
  logic [2:0] in_sel;
  logic [3:0] out_sel;
  logic [7:0] num1, num2, out;
  logic       carry, zero, overflow, busy, done;
  logic [1:0] curr_state, next_state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] in_sel;
    logic [3:0] op;
    logic [7:0] n1;
    logic [7:0] n2;
    logic       st;
    logic [7:0] e_out;
    logic       e_c;
    logic       e_v;
    logic       e_d;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[22];

  alu_accum_fsm #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_sel(in_sel), .out_sel(out_sel),
    .num1(num1), .num2(num2), .start(start), .out(out), .carry(carry),
    .zero(zero), .overflow(overflow), .busy(busy), .done(done),
    .curr_state(curr_state), .next_state(next_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] s, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic st);
    in_sel = s; out_sel = op; num1 = a; num2 = b; start = st;
  endtask

  task automatic chk_all(input string name, input int idx, input logic [7:0] e_out, input logic e_c,
                         input logic e_v, input logic e_d, input logic e_b, input logic [1:0] e_st);
    chk({name, ".out"}, idx, 32'(out), 32'(e_out));
    chk({name, ".carry"}, idx, 32'(carry), 32'(e_c));
    chk({name, ".ovf"}, idx, 32'(overflow), 32'(e_v));
    chk({name, ".zero"}, idx, 32'(zero), 32'(e_out == 8'h00));
    chk({name, ".done"}, idx, 32'(done), 32'(e_d));
    chk({name, ".busy"}, idx, 32'(busy), 32'(e_b));
    chk({name, ".state"}, idx, 32'(curr_state), 32'(e_st));
  endtask

  initial begin
    //           in_sel  op     num1   num2   st    out    c     v     done  state
    vecs[0]  = '{3'b010, 4'd0,  8'h57, 8'h1A, 1'b1, 8'h71, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[1]  = '{3'b100, 4'd1,  8'h00, 8'h1A, 1'b1, 8'h57, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[2]  = '{3'b100, 4'd0,  8'h00, 8'h29, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 2'b10};
    vecs[3]  = '{3'b100, 4'd0,  8'h00, 8'h29, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 2'b10};
    vecs[4]  = '{3'b000, 4'd1,  8'h00, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 2'b10};
    vecs[5]  = '{3'b010, 4'd1,  8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[6]  = '{3'b010, 4'd6,  8'h80, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[7]  = '{3'b010, 4'd7,  8'h03, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[8]  = '{3'b100, 4'd8,  8'h00, 8'hF0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[9]  = '{3'b100, 4'd2,  8'h00, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[10] = '{3'b100, 4'd3,  8'h00, 8'h0F, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[11] = '{3'b100, 4'd4,  8'h00, 8'hFF, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[12] = '{3'b100, 4'd5,  8'h00, 8'h00, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[13] = '{3'b100, 4'd12, 8'h00, 8'h55, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[14] = '{3'b011, 4'd0,  8'h44, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[15] = '{3'b100, 4'd7,  8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[16] = '{3'b010, 4'd0,  8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 2'b01};
    vecs[17] = '{3'b010, 4'd1,  8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 2'b01};
    vecs[18] = '{3'b100, 4'd6,  8'h00, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 2'b10};
    vecs[19] = '{3'b000, 4'd0,  8'h00, 8'h00, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 2'b10};
    vecs[20] = '{3'b001, 4'd0,  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00};
    vecs[21] = '{3'b010, 4'd8,  8'h00, 8'h33, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 2'b01};

    drive(3'b000, 4'd0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 chk_all("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      drive(vecs[i].in_sel, vecs[i].op, vecs[i].n1, vecs[i].n2, vecs[i].st);
      step();
      chk_all("vec", i, vecs[i].e_out, vecs[i].e_c, vecs[i].e_v, vecs[i].e_d, 1'b0, vecs[i].e_st);
    end

    // MUL 0x57*0x1A = 0x08D6; a start held high during busy must be ignored.
    drive(3'b010, 4'd9, 8'h57, 8'h1A, 1'b1);
    step();
    chk_all("mul_k", 0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    drive(3'b010, 4'd8, 8'h01, 8'h99, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk_all("mul_busy", i, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
      chk("mul_next", i, 32'(next_state), (i == 7) ? 32'd1 : 32'd3);
    end
    step();
    chk_all("mul_done", 8, 8'hD6, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    drive(3'b010, 4'd0, 8'h00, 8'h00, 1'b0);
    step();
    chk_all("mul_after", 9, 8'hD6, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);

    // Clear during MUL aborts it without a done pulse.
    drive(3'b010, 4'd9, 8'h57, 8'h1A, 1'b1);
    step();
    drive(3'b100, 4'd8, 8'h00, 8'h55, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_all("abort_busy", i, 8'hD6, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11);
    end
    drive(3'b001, 4'd8, 8'h00, 8'h55, 1'b1);
    #1 chk("abort_next", 4, 32'(next_state), 32'd0);
    step();
    chk_all("abort", 4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    drive(3'b001, 4'd0, 8'h00, 8'h00, 1'b0);
    step();
    chk_all("abort_after", 5, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // Asynchronous reset in the middle of a MUL, checked before any clock edge.
    drive(3'b010, 4'd0, 8'h10, 8'h00, 1'b1);
    step();
    chk_all("pre_rst", 0, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
    drive(3'b010, 4'd9, 8'h57, 8'h1A, 1'b1);
    step();
    drive(3'b100, 4'd0, 8'h00, 8'h00, 1'b0);
    step();
    step();
    step();
    chk_all("mid_mul", 3, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    #2 rst_n = 1'b1;
    step();
    chk_all("post_rst", 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
